zet_fetch_seq: RTL and testbench

Parametrised instruction-fetch sequencer for the Zet core. It replaces the fixed five-state walk with a decode-driven sequence: opcode, optional modrm, 0/1/2-byte offset, 0/1/2-byte immediate, then execute. It owns the PC, drives the CPU-side bus interface toward the wishbone bridge, and inserts an interrupt-acknowledge state. It sits between the bus bridge and the decoder/execute datapath.

---
 rtl/zet_fetch_pkg.sv | 15 +
 rtl/zet_fetch_seq_if.sv | 15 +
 rtl/zet_fetch_operand.sv | 15 +
 rtl/zet_fetch_seq.sv | 94 +++++++++
 tb/tb_zet_fetch_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/zet_fetch_pkg.sv
// zet_fetch_pkg: fetch sequencer state encodings and byte sign-extension helper
package zet_fetch_pkg;
  typedef enum logic [2:0] {
    OPCOD = 3'd0,
    DECOD = 3'd1,
    MODRM = 3'd2,
    OFFSE = 3'd3,
    IMMED = 3'd4,
    EXECU = 3'd5,
    INTAK = 3'd6
  } st_t;
  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction
endpackage

// File: rtl/zet_fetch_seq_if.sv
// zet_fetch_seq_if: CPU-side bus between the fetch sequencer and the wishbone bridge
interface zet_fetch_seq_if #(parameter int ADDR_W = 20);
  logic [ADDR_W-1:0] cpu_adr_o;
  logic [15:0]       cpu_dat_i;
  logic [15:0]       cpu_dat_o;
  logic              cpu_byte_o;
  logic              cpu_mem_op;
  logic              cpu_m_io;
  logic              cpu_we_o;
  logic              cpu_block;
  modport master (output cpu_adr_o, cpu_dat_o, cpu_byte_o, cpu_mem_op, cpu_m_io, cpu_we_o,
                  input  cpu_dat_i, cpu_block);
  modport slave  (input  cpu_adr_o, cpu_dat_o, cpu_byte_o, cpu_mem_op, cpu_m_io, cpu_we_o,
                  output cpu_dat_i, cpu_block);
endinterface

// File: rtl/zet_fetch_operand.sv
// zet_fetch_operand: latches a byte (sign-extended) or word operand from the bus
module zet_fetch_operand
  import zet_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        word,
  input  logic [15:0] dat,
  output logic [15:0] val
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) val <= '0;
    else if (ld) val <= word ? dat : sext8(dat[7:0]);
endmodule

// File: rtl/zet_fetch_seq.sv
// zet_fetch_seq: decode-driven instruction fetch sequencer owning the PC and CPU bus
module zet_fetch_seq
  import zet_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = 20'hFFFF0,
  parameter bit              IRQ_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  zet_fetch_seq_if.master   bus,
  input  logic              dec_modrm,
  input  logic [1:0]        dec_off_sz,
  input  logic [1:0]        dec_imm_sz,
  input  logic              exe_wr,
  input  logic              exe_io,
  input  logic              exe_byte,
  input  logic [ADDR_W-1:0] exe_adr,
  input  logic [15:0]       exe_dat,
  input  logic              ld_pc,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              if_flag,
  input  logic              intr,
  input  logic              nmi,
  output logic              inta,
  output logic              nmia,
  output logic [7:0]        opcode_o,
  output logic [7:0]        modrm_o,
  output logic [15:0]       off_o,
  output logic [15:0]       imm_o,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state
);
  st_t st, cs, nx, after_m;
  logic [7:0] modrm_q;
  logic [ADDR_W-1:0] pc_nx;
  logic nmi_q, nmi_pend, wr, adv, irq;
  always_comb begin
    cs = st > INTAK ? OPCOD : st;
    wr = cs == EXECU && exe_wr;
    bus.cpu_mem_op = cs inside {OPCOD, MODRM, OFFSE, IMMED} || wr;
    adv = !(bus.cpu_mem_op && bus.cpu_block);
    irq = IRQ_EN && (nmi_pend || (intr && if_flag));
    after_m = |dec_off_sz ? OFFSE : |dec_imm_sz ? IMMED : EXECU;
    nx = cs == OPCOD ? DECOD :
         cs == DECOD ? (dec_modrm ? MODRM : after_m) :
         cs == MODRM ? after_m :
         cs == OFFSE ? (|dec_imm_sz ? IMMED : EXECU) :
         cs == IMMED ? EXECU :
         cs == EXECU ? (irq ? INTAK : OPCOD) : OPCOD;
    pc_nx = cs inside {OPCOD, MODRM} ? pc + ADDR_W'(1) :
            cs == OFFSE ? pc + ADDR_W'(dec_off_sz[1] ? 2 : 1) :
            cs == IMMED ? pc + ADDR_W'(dec_imm_sz[1] ? 2 : 1) :
            cs == EXECU && ld_pc ? new_pc : pc;
    bus.cpu_adr_o = wr ? exe_adr : pc;
    bus.cpu_we_o = wr;
    bus.cpu_m_io = wr && exe_io;
    bus.cpu_dat_o = wr ? exe_dat : '0;
    bus.cpu_byte_o = wr ? exe_byte :
                     cs == OFFSE ? !dec_off_sz[1] :
                     cs == IMMED ? !dec_imm_sz[1] : 1'b1;
    // decoder needs the modrm byte in the same cycle it arrives
    modrm_o = cs == MODRM ? bus.cpu_dat_i[7:0] : modrm_q;
    inta = IRQ_EN && cs == INTAK && !nmi_pend;
    nmia = IRQ_EN && cs == INTAK && nmi_pend;
    state = st;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= OPCOD;
      pc <= RESET_PC;
      opcode_o <= '0;
      modrm_q <= '0;
      nmi_q <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q <= nmi;
      nmi_pend <= (nmi && !nmi_q) || (nmi_pend && cs != INTAK);
      if (adv) begin
        st <= nx;
        pc <= pc_nx;
        if (cs == OPCOD) opcode_o <= bus.cpu_dat_i[7:0];
        if (cs == MODRM) modrm_q <= bus.cpu_dat_i[7:0];
      end
    end
  zet_fetch_operand u_off (
    .clk(clk), .rst(rst), .ld(adv && cs == OFFSE), .word(dec_off_sz[1]),
    .dat(bus.cpu_dat_i), .val(off_o)
  );
  zet_fetch_operand u_imm (
    .clk(clk), .rst(rst), .ld(adv && cs == IMMED), .word(dec_imm_sz[1]),
    .dat(bus.cpu_dat_i), .val(imm_o)
  );
endmodule

// File: tb/tb_zet_fetch_seq.sv
// tb_zet_fetch_seq: directed checks of fetch walk, stalls, execute writes and interrupts
module tb_zet_fetch_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dec_modrm = 1'b0;
  logic [1:0] dec_off_sz = '0, dec_imm_sz = '0;
  logic exe_wr = 1'b0, exe_io = 1'b0, exe_byte = 1'b0;
  logic [19:0] exe_adr = '0, new_pc = '0;
  logic [15:0] exe_dat = '0;
  logic ld_pc = 1'b0, if_flag = 1'b0, intr = 1'b0, nmi = 1'b0;
  logic inta, nmia;
  logic [7:0] opcode_o, modrm_o;
  logic [15:0] off_o, imm_o;
  logic [19:0] pc;
  logic [2:0] state;
  logic [7:0] mem [16];
  int n_run = 0;
  int n_fail = 0;

  zet_fetch_seq_if #(.ADDR_W(20)) bus ();

  zet_fetch_seq dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dec_modrm(dec_modrm), .dec_off_sz(dec_off_sz), .dec_imm_sz(dec_imm_sz),
    .exe_wr(exe_wr), .exe_io(exe_io), .exe_byte(exe_byte), .exe_adr(exe_adr), .exe_dat(exe_dat),
    .ld_pc(ld_pc), .new_pc(new_pc), .if_flag(if_flag), .intr(intr), .nmi(nmi),
    .inta(inta), .nmia(nmia), .opcode_o(opcode_o), .modrm_o(modrm_o),
    .off_o(off_o), .imm_o(imm_o), .pc(pc), .state(state)
  );

  always #5 clk = ~clk;

  // byte memory aliased on the low address nibble, word reads wrap within it
  always_comb begin
    logic [3:0] a;
    a = bus.cpu_adr_o[3:0];
    bus.cpu_dat_i = bus.cpu_byte_o ? {8'h00, mem[a]} : {mem[a + 4'd1], mem[a]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem = '{8'h90, 8'h89, 8'h06, 8'h34, 8'h12, 8'hFE, 8'h8B, 8'h46,
            8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC7, 8'h78, 8'h56};
    bus.cpu_block = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 32'hFFFF0);
    chk("rst_opcode", 32'(opcode_o), 0);
    chk("rst_ack", {inta, nmia}, 0);
    rst = 1'b1;
    #1;
    chk("first_adr", 32'(bus.cpu_adr_o), 32'hFFFF0);
    chk("first_byte", 32'(bus.cpu_byte_o), 1);
    chk("first_we", 32'(bus.cpu_we_o), 0);
    chk("first_memop", 32'(bus.cpu_mem_op), 1);
    // NOP: OPCOD, DECOD, EXECU, OPCOD
    cyc();
    chk("nop_s1", 32'(state), 1);
    chk("nop_opc", 32'(opcode_o), 32'h90);
    chk("nop_pc", 32'(pc), 32'hFFFF1);
    chk("nop_dec_memop", 32'(bus.cpu_mem_op), 0);
    cyc();
    chk("nop_s5", 32'(state), 5);
    chk("nop_we", 32'(bus.cpu_we_o), 0);
    chk("nop_dato", 32'(bus.cpu_dat_o), 0);
    cyc();
    chk("nop_s0", 32'(state), 0);
    chk("nop_pc2", 32'(pc), 32'hFFFF1);
    // 89 06 34 12 FE: modrm, word offset, byte immediate
    dec_modrm = 1'b1; dec_off_sz = 2'd2; dec_imm_sz = 2'd1;
    cyc();
    chk("mov_s1", 32'(state), 1);
    chk("mov_opc", 32'(opcode_o), 32'h89);
    cyc();
    chk("mov_s2", 32'(state), 2);
    chk("mov_modrm_comb", 32'(modrm_o), 32'h06);
    cyc();
    chk("mov_s3", 32'(state), 3);
    chk("mov_pc3", 32'(pc), 32'hFFFF3);
    chk("mov_modrm_reg", 32'(modrm_o), 32'h06);
    chk("mov_off_byte", 32'(bus.cpu_byte_o), 0);
    cyc();
    chk("mov_s4", 32'(state), 4);
    chk("mov_off", 32'(off_o), 32'h1234);
    chk("mov_pc4", 32'(pc), 32'hFFFF5);
    chk("mov_imm_byte", 32'(bus.cpu_byte_o), 1);
    cyc();
    chk("mov_s5", 32'(state), 5);
    chk("mov_imm", 32'(imm_o), 32'hFFFE);
    chk("mov_pc5", 32'(pc), 32'hFFFF6);
    cyc();
    chk("mov_s0", 32'(state), 0);
    // 8B 46 80 with stall in OFFSE, then execute write with branch
    dec_off_sz = 2'd1; dec_imm_sz = 2'd0;
    cyc();
    chk("stl_opc", 32'(opcode_o), 32'h8B);
    cyc();
    chk("stl_s2", 32'(state), 2);
    cyc();
    chk("stl_s3", 32'(state), 3);
    chk("stl_adr", 32'(bus.cpu_adr_o), 32'hFFFF8);
    bus.cpu_block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stl_hold_s", 32'(state), 3);
      chk("stl_hold_pc", 32'(pc), 32'hFFFF8);
      chk("stl_hold_adr", 32'(bus.cpu_adr_o), 32'hFFFF8);
    end
    bus.cpu_block = 1'b0;
    exe_wr = 1'b1; exe_adr = 20'h00400; exe_dat = 16'hABCD; exe_byte = 1'b0;
    ld_pc = 1'b1; new_pc = 20'hFFFFD;
    cyc();
    chk("wr_s5", 32'(state), 5);
    chk("wr_off_sext", 32'(off_o), 32'hFF80);
    chk("wr_pc", 32'(pc), 32'hFFFF9);
    chk("wr_we", 32'(bus.cpu_we_o), 1);
    chk("wr_dato", 32'(bus.cpu_dat_o), 32'hABCD);
    chk("wr_adr", 32'(bus.cpu_adr_o), 32'h00400);
    chk("wr_byte", 32'(bus.cpu_byte_o), 0);
    chk("wr_mio", 32'(bus.cpu_m_io), 0);
    bus.cpu_block = 1'b1;
    cyc();
    chk("wr_hold_s", 32'(state), 5);
    chk("wr_hold_pc", 32'(pc), 32'hFFFF9);
    bus.cpu_block = 1'b0;
    cyc();
    chk("br_s0", 32'(state), 0);
    chk("br_pc", 32'(pc), 32'hFFFFD);
    // C7 with word immediate at top address, nmi arriving during IMMED
    exe_wr = 1'b0; ld_pc = 1'b0;
    dec_modrm = 1'b0; dec_off_sz = 2'd0; dec_imm_sz = 2'd3;
    intr = 1'b1; if_flag = 1'b1;
    cyc();
    chk("irq_opc", 32'(opcode_o), 32'hC7);
    cyc();
    chk("irq_s4", 32'(state), 4);
    chk("irq_imm_word", 32'(bus.cpu_byte_o), 0);
    nmi = 1'b1;
    cyc();
    chk("irq_s5", 32'(state), 5);
    chk("irq_imm", 32'(imm_o), 32'h5678);
    chk("irq_pc_wrap", 32'(pc), 32'h00000);
    cyc();
    chk("nmi_s6", 32'(state), 6);
    chk("nmi_ack", {inta, nmia}, 32'b01);
    chk("nmi_memop", 32'(bus.cpu_mem_op), 0);
    dec_imm_sz = 2'd0;
    cyc();
    chk("nmi_s0", 32'(state), 0);
    chk("nmi_ack_off", {inta, nmia}, 0);
    cyc();
    cyc();
    chk("int_s5", 32'(state), 5);
    cyc();
    chk("int_s6", 32'(state), 6);
    chk("int_ack", {inta, nmia}, 32'b10);
    intr = 1'b0;
    cyc();
    chk("int_s0", 32'(state), 0);
    cyc();
    chk("ar_s1", 32'(state), 1);
    #3 rst = 1'b0;
    #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_pc", 32'(pc), 32'hFFFF0);
    chk("ar_opc", 32'(opcode_o), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
